// File: rtl/uart_bus_arbiter_n_if.sv
// Bus bundle between the CPU data port, the UART channels and the status-write arbiter.
// The master side drives CPU and channel levels; the slave side is the arbiter.
interface uart_bus_arbiter_n_if #(
    parameter int unsigned NCH    = 2,
    parameter int unsigned ADDR_W = 32
);
    logic [ADDR_W-1:0] address;
    logic              memReadCPU;
    logic              memWriteCPU;
    logic [NCH-1:0]    readyRx;
    logic [NCH-1:0]    busyTx;
    logic [NCH-1:0]    txEnable;
    logic [NCH-1:0]    grant;
    logic              memWriteOut;
    logic [ADDR_W-1:0] addressOut;
    logic              dataSel;
    logic [NCH-1:0]    overrun;

    modport master (
        output address,
        output memReadCPU,
        output memWriteCPU,
        output readyRx,
        output busyTx,
        input  txEnable,
        input  grant,
        input  memWriteOut,
        input  addressOut,
        input  dataSel,
        input  overrun
    );

    modport slave (
        input  address,
        input  memReadCPU,
        input  memWriteCPU,
        input  readyRx,
        input  busyTx,
        output txEnable,
        output grant,
        output memWriteOut,
        output addressOut,
        output dataSel,
        output overrun
    );
endinterface

// File: rtl/uart_bus_arbiter_n.sv
// Round-robin arbiter turning per-channel UART RX/TX edge events into single-cycle
// status/data writes on the shared memory port whenever the CPU leaves the bus idle.
module uart_bus_arbiter_n #(
    parameter int unsigned NCH         = 2,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned UART_BASE   = 32'h0000_0F00,
    parameter int unsigned UART_STRIDE = 16
) (
    input logic                 clk,
    input logic                 rst,
    uart_bus_arbiter_n_if.slave bus
);
    localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [NCH-1:0]    chvec_t;

    function automatic addr_t chan_base(input int unsigned ch);
        return addr_t'(UART_BASE + ch * UART_STRIDE);
    endfunction

    chvec_t        rxPrev_q,     rxPrev_d;
    chvec_t        txPrev_q,     txPrev_d;
    chvec_t        rxDataPend_q, rxDataPend_d;
    chvec_t        rxFlagPend_q, rxFlagPend_d;
    chvec_t        txFlagPend_q, txFlagPend_d;
    chvec_t        overrun_q,    overrun_d;
    logic [CW-1:0] last_q,       last_d;
    logic          primed_q;

    chvec_t        rxRise, rxFall, txFall;
    chvec_t        anyPend;
    chvec_t        grant_c;
    chvec_t        clrTx, clrRxF, clrRxD;
    chvec_t        txEn_c;
    logic          busFree;
    logic          found;
    logic [CW-1:0] sel;
    addr_t         addr_c;
    logic          dsel_c;

    always_comb begin
        // Edges are suppressed for the first cycle out of reset so that levels
        // already high at release are captured as history, not as new events.
        rxRise  = bus.readyRx & ~rxPrev_q & {NCH{primed_q}};
        rxFall  = ~bus.readyRx & rxPrev_q & {NCH{primed_q}};
        txFall  = ~bus.busyTx & txPrev_q & {NCH{primed_q}};
        busFree = !bus.memReadCPU && !bus.memWriteCPU;
        anyPend = txFlagPend_q | rxFlagPend_q | rxDataPend_q;

        found = 1'b0;
        sel   = '0;
        for (int unsigned off = 1; off <= NCH; off++) begin
            for (int unsigned ch = 0; ch < NCH; ch++) begin
                if (!found && busFree && anyPend[ch] &&
                    ch == (32'(last_q) + off) % NCH) begin
                    found = 1'b1;
                    sel   = CW'(ch);
                end
            end
        end

        grant_c = '0;
        for (int unsigned ch = 0; ch < NCH; ch++) begin
            grant_c[ch] = found && (sel == CW'(ch));
        end

        addr_c = '0;
        dsel_c = 1'b0;
        clrTx  = '0;
        clrRxF = '0;
        clrRxD = '0;
        for (int unsigned ch = 0; ch < NCH; ch++) begin
            if (grant_c[ch]) begin
                if (txFlagPend_q[ch]) begin
                    addr_c    = chan_base(ch) + addr_t'(12);
                    dsel_c    = 1'b1;
                    clrTx[ch] = 1'b1;
                end else if (rxFlagPend_q[ch]) begin
                    addr_c     = chan_base(ch) + addr_t'(8);
                    dsel_c     = 1'b1;
                    clrRxF[ch] = 1'b1;
                end else begin
                    addr_c     = chan_base(ch) + addr_t'(4);
                    dsel_c     = 1'b0;
                    clrRxD[ch] = 1'b1;
                end
            end
        end

        // A new edge on the bit being serviced keeps it set; only an edge on a
        // bit that stays pending counts as a lost event.
        txFlagPend_d = (txFlagPend_q & ~clrTx)  | txFall;
        rxFlagPend_d = (rxFlagPend_q & ~clrRxF) | rxFall;
        rxDataPend_d = (rxDataPend_q & ~clrRxD) | rxRise;
        overrun_d    = overrun_q
                     | (txFall & txFlagPend_q & ~clrTx)
                     | (rxFall & rxFlagPend_q & ~clrRxF)
                     | (rxRise & rxDataPend_q & ~clrRxD);
        rxPrev_d     = bus.readyRx;
        txPrev_d     = bus.busyTx;
        last_d       = found ? sel : last_q;

        txEn_c = '0;
        for (int unsigned ch = 0; ch < NCH; ch++) begin
            txEn_c[ch] = !rst && bus.memWriteCPU && (bus.address == chan_base(ch)) &&
                         !bus.busyTx[ch] && !txFlagPend_q[ch];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxPrev_q     <= '0;
            txPrev_q     <= '0;
            rxDataPend_q <= '0;
            rxFlagPend_q <= '0;
            txFlagPend_q <= '0;
            overrun_q    <= '0;
            last_q       <= CW'(NCH - 1);
            primed_q     <= 1'b0;
        end else begin
            rxPrev_q     <= rxPrev_d;
            txPrev_q     <= txPrev_d;
            rxDataPend_q <= rxDataPend_d;
            rxFlagPend_q <= rxFlagPend_d;
            txFlagPend_q <= txFlagPend_d;
            overrun_q    <= overrun_d;
            last_q       <= last_d;
            primed_q     <= 1'b1;
        end
    end

    assign bus.grant       = grant_c;
    assign bus.memWriteOut = |grant_c;
    assign bus.addressOut  = addr_c;
    assign bus.dataSel     = dsel_c;
    assign bus.txEnable    = txEn_c;
    assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_uart_bus_arbiter_n.sv
// Scoreboard bench for uart_bus_arbiter_n: a per-cycle event model predicts
// grants, txEnable and overrun; a negedge monitor compares against the DUT.
module tb_uart_bus_arbiter_n;
    localparam int unsigned NCH    = 2;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned BASE   = 32'h0000_0F00;
    localparam int unsigned STRIDE = 16;
    localparam int unsigned OFFS [3] = '{12, 8, 4};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_bus_arbiter_n_if #(.NCH(NCH), .ADDR_W(ADDR_W)) bus_if ();

    uart_bus_arbiter_n #(
        .NCH(NCH), .ADDR_W(ADDR_W), .UART_BASE(BASE), .UART_STRIDE(STRIDE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    typedef struct {
        int                cyc;
        logic [NCH-1:0]    grant;
        logic [ADDR_W-1:0] addr;
        logic              dsel;
    } gexp_t;

    typedef struct {
        int             cyc;
        logic [NCH-1:0] txen;
        logic [NCH-1:0] ovr;
    } cexp_t;

    gexp_t gq [$];
    cexp_t cq [$];
    gexp_t ge;
    cexp_t ce;
    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;

    // Model state: pending events per channel, kind 0 = TX done, 1 = RX flag, 2 = RX data.
    bit             pend [NCH][3];
    bit             ovr  [NCH];
    int unsigned    last;
    bit             fresh;
    logic [NCH-1:0] prx, ptx;
    logic [NCH-1:0] crx, ctx;

    function automatic logic [ADDR_W-1:0] base_of(input int unsigned c);
        return ADDR_W'(BASE + c * STRIDE);
    endfunction

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endfunction

    function automatic void model_step(input logic r, input logic [NCH-1:0] rx, input logic [NCH-1:0] tx,
                                       input logic rd, input logic wr, input logic [ADDR_W-1:0] a);
        cexp_t       c;
        gexp_t       g;
        int          sch;
        int          skind;
        bit          ev [3];
        c.cyc = cyc;
        c.txen = '0;
        c.ovr  = '0;
        if (r) begin
            for (int ch = 0; ch < NCH; ch++) begin
                for (int k = 0; k < 3; k++) pend[ch][k] = 1'b0;
                ovr[ch] = 1'b0;
            end
            last  = NCH - 1;
            fresh = 1'b1;
            cq.push_back(c);
            return;
        end
        for (int ch = 0; ch < NCH; ch++) begin
            c.txen[ch] = wr && (a == base_of(ch)) && !tx[ch] && !pend[ch][0];
            c.ovr[ch]  = ovr[ch];
        end
        cq.push_back(c);

        sch   = -1;
        skind = -1;
        if (!rd && !wr) begin
            for (int unsigned k = 1; k <= NCH && sch < 0; k++) begin
                int unsigned ch;
                ch = (last + k) % NCH;
                for (int t = 0; t < 3 && sch < 0; t++) begin
                    if (pend[ch][t]) begin
                        sch   = int'(ch);
                        skind = t;
                    end
                end
            end
        end
        if (sch >= 0) begin
            g.cyc   = cyc;
            g.grant = NCH'(1) << sch;
            g.addr  = base_of(sch) + OFFS[skind];
            g.dsel  = (skind != 2);
            gq.push_back(g);
            last = sch;
        end

        for (int ch = 0; ch < NCH; ch++) begin
            if (fresh) begin
                ev[0] = 0; ev[1] = 0; ev[2] = 0;
            end else begin
                ev[0] = ptx[ch] && !tx[ch];
                ev[1] = prx[ch] && !rx[ch];
                ev[2] = !prx[ch] && rx[ch];
            end
            for (int t = 0; t < 3; t++) begin
                bit served;
                served = (sch == ch) && (skind == t);
                if (ev[t] && pend[ch][t] && !served) ovr[ch] = 1'b1;
                if (served) pend[ch][t] = 1'b0;
                if (ev[t]) pend[ch][t] = 1'b1;
            end
        end
        fresh = 1'b0;
        prx = rx;
        ptx = tx;
    endfunction

    task automatic step(input logic r, input logic [NCH-1:0] rx, input logic [NCH-1:0] tx,
                        input logic rd, input logic wr, input logic [ADDR_W-1:0] a);
        @(posedge clk);
        #1;
        cyc++;
        rst                = r;
        bus_if.readyRx     = rx;
        bus_if.busyTx      = tx;
        bus_if.memReadCPU  = rd;
        bus_if.memWriteCPU = wr;
        bus_if.address     = a;
        crx = rx;
        ctx = tx;
        model_step(r, rx, tx, rd, wr, a);
    endtask

    always @(negedge clk) begin
        if (cq.size() > 0 && cq[0].cyc == cyc) begin
            ce = cq.pop_front();
            chk("txEnable", 64'(bus_if.txEnable), 64'(ce.txen));
            chk("overrun", 64'(bus_if.overrun), 64'(ce.ovr));
        end
        if (gq.size() > 0 && gq[0].cyc == cyc) begin
            ge = gq.pop_front();
            chk("grant", 64'(bus_if.grant), 64'(ge.grant));
            chk("addressOut", 64'(bus_if.addressOut), 64'(ge.addr));
            chk("dataSel", 64'(bus_if.dataSel), 64'(ge.dsel));
            chk("memWriteOut", 64'(bus_if.memWriteOut), 64'd1);
        end else begin
            chk("idle_grant", 64'(bus_if.grant), 64'd0);
            chk("idle_memWriteOut", 64'(bus_if.memWriteOut), 64'd0);
            chk("idle_addressOut", 64'(bus_if.addressOut), 64'd0);
            chk("idle_dataSel", 64'(bus_if.dataSel), 64'd0);
        end
    end

    initial begin
        logic              rr, rd, wr;
        logic [ADDR_W-1:0] a;
        int unsigned       k;
        bus_if.readyRx     = '0;
        bus_if.busyTx      = '0;
        bus_if.memReadCPU  = 1'b0;
        bus_if.memWriteCPU = 1'b0;
        bus_if.address     = '0;
        crx = '0;
        ctx = '0;
        prx = '0;
        ptx = '0;

        step(1, 2'b00, 2'b00, 0, 0, '0);
        step(1, 2'b00, 2'b00, 0, 0, '0);
        step(0, 2'b00, 2'b00, 0, 0, '0);
        step(0, 2'b00, 2'b00, 0, 0, '0);

        // single RX data event, then its falling-edge flag
        step(0, 2'b01, 2'b00, 0, 0, '0);
        step(0, 2'b01, 2'b00, 0, 0, '0);
        step(0, 2'b01, 2'b00, 0, 0, '0);
        step(0, 2'b00, 2'b00, 0, 0, '0);
        step(0, 2'b00, 2'b00, 0, 0, '0);
        step(0, 2'b00, 2'b00, 0, 0, '0);

        // TX done on ch1 together with RX data on ch0
        step(0, 2'b00, 2'b10, 0, 0, '0);
        step(0, 2'b01, 2'b00, 0, 0, '0);
        step(0, 2'b01, 2'b00, 0, 0, '0);
        step(0, 2'b01, 2'b00, 0, 0, '0);
        step(0, 2'b01, 2'b00, 0, 0, '0);

        // TX start strobe depends on busyTx and the exact base address
        step(0, 2'b01, 2'b00, 0, 1, base_of(1));
        step(0, 2'b01, 2'b10, 0, 1, base_of(1));
        step(0, 2'b01, 2'b10, 0, 1, base_of(1) + 4);
        step(0, 2'b01, 2'b00, 0, 1, base_of(0) + 12);
        step(0, 2'b01, 2'b00, 0, 0, '0);

        // both channels pending while the CPU stores for three cycles
        step(0, 2'b10, 2'b00, 0, 1, base_of(0));
        step(0, 2'b10, 2'b00, 0, 1, base_of(0));
        step(0, 2'b10, 2'b00, 0, 1, base_of(1));
        step(0, 2'b10, 2'b00, 0, 0, '0);
        step(0, 2'b10, 2'b00, 0, 0, '0);
        step(0, 2'b10, 2'b00, 0, 0, '0);
        step(0, 2'b00, 2'b00, 0, 0, '0);
        step(0, 2'b00, 2'b00, 0, 0, '0);

        // readyRx[0] toggles twice under a busy bus
        step(0, 2'b01, 2'b00, 1, 0, '0);
        step(0, 2'b00, 2'b00, 1, 0, '0);
        step(0, 2'b01, 2'b00, 1, 0, '0);
        step(0, 2'b00, 2'b00, 1, 0, '0);
        step(0, 2'b00, 2'b00, 0, 0, '0);
        step(0, 2'b00, 2'b00, 0, 0, '0);
        step(0, 2'b00, 2'b00, 0, 0, '0);

        // asynchronous reset with events pending; levels stay high across release
        step(0, 2'b11, 2'b11, 1, 0, '0);
        step(0, 2'b11, 2'b00, 1, 0, '0);
        step(1, 2'b11, 2'b00, 0, 1, base_of(0));
        #1;
        chk("rst_grant", 64'(bus_if.grant), 64'd0);
        chk("rst_memWriteOut", 64'(bus_if.memWriteOut), 64'd0);
        chk("rst_addressOut", 64'(bus_if.addressOut), 64'd0);
        chk("rst_txEnable", 64'(bus_if.txEnable), 64'd0);
        chk("rst_overrun", 64'(bus_if.overrun), 64'd0);
        step(1, 2'b11, 2'b00, 0, 0, '0);
        for (int i = 0; i < 4; i++) step(0, 2'b11, 2'b00, 0, 0, '0);
        step(0, 2'b10, 2'b00, 0, 0, '0);
        step(0, 2'b10, 2'b00, 0, 0, '0);
        step(0, 2'b10, 2'b00, 0, 0, '0);

        for (int n = 0; n < 3000; n++) begin
            logic [NCH-1:0] nrx, ntx;
            nrx = crx;
            ntx = ctx;
            rr = ($urandom_range(0, 299) == 0);
            for (int ch = 0; ch < NCH; ch++) begin
                if ($urandom_range(0, 5) == 0) nrx[ch] = ~nrx[ch];
                if ($urandom_range(0, 5) == 0) ntx[ch] = ~ntx[ch];
            end
            k  = $urandom_range(0, 9);
            rd = (k < 2);
            wr = (k >= 2 && k < 4);
            case ($urandom_range(0, 4))
                0:       a = base_of(0);
                1:       a = base_of(NCH - 1);
                2:       a = base_of($urandom_range(0, NCH - 1)) + 4;
                3:       a = base_of($urandom_range(0, NCH - 1)) + 12;
                default: a = ADDR_W'($urandom);
            endcase
            step(rr, nrx, ntx, rd, wr, a);
        end

        for (int i = 0; i < 8; i++) step(0, crx, ctx, 0, 0, '0);
        @(negedge clk);
        #1;
        chk("leftover_grants", 64'(gq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_bus_arbiter_n.md
UART_BUS_ARBITER_N -- requirements
Module: uart_bus_arbiter_n

Interface
REQ-001 SHALL provide parameter NCH, default 2, number of UART channels (1..8).
REQ-002 SHALL provide parameter ADDR_W, default 32, data-memory address width.
REQ-003 SHALL provide parameter UART_BASE, default 32'h0000_0F00, channel-0 register block base.
REQ-004 SHALL provide parameter UART_STRIDE, default 16, byte spacing between channel blocks; channel i base Bi = UART_BASE + i*UART_STRIDE.
REQ-005 SHALL use one clock, clk, with asynchronous, active-high reset rst.
REQ-006 SHALL have ports:
  clk  in  1  clock
  rst  in  1  async active-high reset
  address  in  ADDR_W  CPU data address
  memReadCPU  in  1  CPU load this cycle
  memWriteCPU  in  1  CPU store this cycle
  readyRx  in  NCH  per-channel RX byte ready (level)
  busyTx  in  NCH  per-channel TX busy (level)
  txEnable  out  NCH  per-channel TX start strobe
  grant  out  NCH  one-hot channel owning the memory write port
  memWriteOut  out  1  arbiter memory write
  addressOut  out  ADDR_W  arbiter write address
  dataSel  out  1  0 = RX data, 1 = status flag word
  overrun  out  NCH  sticky lost-event flag

Function
REQ-007 SHALL register readyRx and busyTx each cycle (rxPrev, txPrev) for edge detection.
REQ-008 SHALL set rxDataPend[i] on a readyRx[i] rising edge, rxFlagPend[i] on a readyRx[i] falling edge, txFlagPend[i] on a busyTx[i] falling edge.
REQ-009 SHALL set overrun[i] when an edge arrives while the matching pending bit is set and not being cleared that cycle; pending bit stays 1; no event queued twice.
REQ-010 SHALL treat the bus as free when memReadCPU=0 and memWriteCPU=0; no grant while the bus is busy.
REQ-011 SHALL, when the bus is free and any pending bit is set, assert exactly one grant bit combinationally in that cycle.
REQ-012 SHALL choose the channel round-robin: search starts at channel (last+1) mod NCH, where last is the most recently granted channel; last = NCH-1 after reset, so channel 0 wins first.
REQ-013 SHALL service one event per grant, in-channel priority txFlag > rxFlag > rxData.
REQ-014 SHALL drive addressOut = Bi+12, dataSel=1 (txFlag); Bi+8, dataSel=1 (rxFlag); Bi+4, dataSel=0 (rxData); else addressOut=0, dataSel=0.
REQ-015 SHALL assert memWriteOut = |grant and clear the serviced pending bit at the clock edge ending the grant cycle.
REQ-016 SHALL have latency: edge at cycle k input, pending visible cycle k+1, earliest grant cycle k+1.
REQ-017 SHALL assert txEnable[i] = memWriteCPU & (address == Bi) & !busyTx[i] & !txFlagPend[i], combinational.
REQ-018 SHALL ignore CPU stores to Bi+4/+8/+12 (no txEnable).
REQ-019 SHALL, on a simultaneous set and clear of the same pending bit, keep the bit set (new event wins).

Reset
REQ-020 SHALL, while rst=1, clear all pending bits, rxPrev, txPrev and overrun, set last=NCH-1, and hold grant=0, memWriteOut=0, txEnable=0, addressOut=0, dataSel=0.
REQ-021 SHALL drop any in-progress event on reset mid-operation; after release, high readyRx/busyTx levels produce no event until their next edge.

Verification
REQ-022 NCH=2: readyRx=01 rise, bus free -> next cycle grant=01, addressOut=0x0F04, dataSel=0, memWriteOut=1 for one cycle.
REQ-023 busyTx[1] falls and readyRx[0] rises in the same cycle, bus free -> grant=01 (0x0F04), then grant=10 (0x0F1C, dataSel=1).
REQ-024 Both channels pending, memWriteCPU=1 for 3 cycles -> grant=00, txEnable follows only the address match; grants resume the cycle the bus frees.
REQ-025 Store to 0x0F10 with busyTx=00 -> txEnable=10; same store with busyTx=10 -> txEnable=00.
REQ-026 readyRx[0] toggles twice while the bus is busy -> overrun[0]=1, one rxData and one rxFlag grant served afterwards.
REQ-027 rst=1 while pending bits set -> all outputs 0 immediately (async), no grants after release until a new edge.
